pl_ram_cmd_engine: RTL and testbench
====================================

Name: pl_ram_cmd_engine

Overview:
- Datapath stage directly downstream of the pl_ram_ctrl AXI4-Lite register slave.
- Consumes the slave's command registers (start, op, base, length, seed).
- Executes sequential fill or check passes over a single-port PL block RAM.
- Returns busy/done/error status back to the slave's readable registers.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM depth = 2^ADDR_W.
- DATA_W, 32, RAM data width and pattern width.
- LEN_W, 11, width of length field; maximum length 2^LEN_W-1.
- CNT_W, 16, error counter width.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle command pulse from register slave.
- op  in  1  0 = FILL (write pattern), 1 = CHECK (read and compare).
- base_addr  in  ADDR_W  first RAM word address.
- length  in  LEN_W  number of words to process.
- seed  in  DATA_W  pattern seed; word i expects/gets seed+i.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse at pass completion.
- err_cnt  out  CNT_W  mismatches in last CHECK pass.
- err_seen  out  1  at least one mismatch in last CHECK pass.
- first_err_addr  out  ADDR_W  address of first mismatch.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after a read enable.

Behaviour:
- Reset (ARESETN low, async): state IDLE; all outputs 0; idx, expected pipeline and counters cleared.
- Reset asserted mid-pass aborts immediately; no done pulse; RAM contents undefined for the partial pass.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches op/base/length/seed.
  - Clears err_cnt, err_seen, first_err_addr.
  - length=0 -> DONE next cycle; else -> RUN next cycle.
  - start while not IDLE is ignored: no latch, no effect.
- RUN:
  - One word per cycle, idx 0..length-1.
  - ram_en=1; ram_addr=(base+idx) mod 2^ADDR_W, so addresses wrap past the top of the RAM.
  - FILL: ram_we=1, ram_wdata=(seed+idx) mod 2^DATA_W.
  - CHECK: ram_we=0; expected value and address are registered alongside the request.
  - At idx=length-1: FILL -> DONE; CHECK -> DRAIN.
- DRAIN (CHECK only): one cycle, ram_en=0, so the last read's data is compared.
- Compare, CHECK only:
  - Each cycle after a read, ram_rdata != expected -> err_cnt+1, saturating at 2^CNT_W-1.
  - On the first mismatch: err_seen=1, first_err_addr=that address.
- DONE: done=1 for exactly one cycle; busy still 1; -> IDLE next cycle.
- Latency from the start cycle (edge k):
  - FILL N words: done high in cycle k+N+1.
  - CHECK N words: done high in cycle k+N+2.
  - length 0: done high in cycle k+1.
- ram_en, ram_we, ram_addr, ram_wdata are 0 outside RUN.
- Status outputs hold until the next accepted start.

Optional Feature:
- Macro: PL_RAM_CMD_ENGINE_IRQ_EN.
- Defined: adds ports irq (out, 1) and irq_clr (in, 1).
  - irq sets on the cycle done pulses and is sticky.
  - irq clears on irq_clr=1.
  - A set and a clear in the same cycle leave irq set.
  - irq resets to 0.
- Undefined: neither port exists; behaviour otherwise identical.

Decomposition:
- Package pl_ram_ctrl_pkg holds:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - op encodings OP_FILL=1'b0, OP_CHECK=1'b1;
  - default width constants shared with the AXI register slave.
- No sub-module inside the engine.
- Companion pl_ram_sp_bram (single-port RAM, 1-cycle read latency) is instantiated beside it at wrapper level and reused by the bench.

Test Plan:
- FILL base=0x000, len=4, seed=0x1 -> RAM[0..3]=1,2,3,4; done 5 cycles after start; busy high 5 cycles.
- CHECK same parameters after that fill -> err_cnt=0, err_seen=0, done 6 cycles after start.
- Bench overwrites RAM[2]=0xDEAD, then CHECK base=0, len=4, seed=1 -> err_cnt=1, err_seen=1, first_err_addr=0x002.
- FILL base=0x3FE, len=4, seed=0xFFFFFFFF -> addresses 0x3FE, 0x3FF, 0x000, 0x001 receive 0xFFFFFFFF, 0x0, 0x1, 0x2.
- len=0 start -> done in next cycle, no ram_en activity. Second start during a len=8 FILL -> ignored, still exactly 8 writes.
- ARESETN low at idx=3 of a len=8 FILL -> all outputs 0 immediately, no done. After release, a new start runs normally.

Source files
------------

// File: rtl/pl_ram_ctrl_pkg.sv
// Types and constants shared by the pl_ram_ctrl register slave and the command engine.
package pl_ram_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 11;
    localparam int CNT_W_DEF  = 16;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_CHECK = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pl_ram_sp_bram.sv
// Single-port block RAM with a registered read port (one cycle read latency).
module pl_ram_sp_bram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array and read register take no reset so the tools can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/pl_ram_cmd_engine.sv
// Sequential FILL/CHECK pass engine for a single-port PL block RAM.
// Optional irq/irq_clr ports are enabled with `define PL_RAM_CMD_ENGINE_IRQ_EN.
module pl_ram_cmd_engine
    import pl_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_seen,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clr
`endif
);

    state_e            state_q, state_d;
    logic              op_q, op_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              exp_vld_q, exp_vld_d;
    logic [DATA_W-1:0] exp_data_q, exp_data_d;
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_seen_q, err_seen_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              is_fill;
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
    logic              irq_q, irq_d;
`endif

    assign is_fill = (op_q == OP_FILL);

    always_comb begin
        // NOTE: every _d starts from a default so no path through the case statement infers a latch.
        state_d          = state_q;
        op_d             = op_q;
        len_d            = len_q;
        idx_d            = idx_q;
        pat_d            = pat_q;
        ram_en_d         = 1'b0;
        ram_we_d         = 1'b0;
        ram_addr_d       = '0;
        ram_wdata_d      = '0;
        exp_vld_d        = 1'b0;
        exp_data_d       = '0;
        exp_addr_d       = '0;
        err_cnt_d        = err_cnt_q;
        err_seen_d       = err_seen_q;
        first_err_addr_d = first_err_addr_q;

        // Read data returns one cycle after the request that carried exp_*.
        if (exp_vld_q && (ram_rdata != exp_data_q)) begin
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (!err_seen_q) begin
                err_seen_d       = 1'b1;
                first_err_addr_d = exp_addr_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d             = op;
                    len_d            = length;
                    idx_d            = '0;
                    pat_d            = seed;
                    err_cnt_d        = '0;
                    err_seen_d       = 1'b0;
                    first_err_addr_d = '0;
                    if (length == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = RUN;
                        ram_en_d    = 1'b1;
                        ram_we_d    = (op == OP_FILL);
                        ram_addr_d  = base_addr;
                        ram_wdata_d = (op == OP_FILL) ? seed : '0;
                    end
                end
            end
            RUN: begin
                exp_vld_d  = !is_fill;
                exp_data_d = pat_q;
                exp_addr_d = ram_addr_q;
                if (idx_q == len_q - LEN_W'(1)) begin
                    state_d = is_fill ? DONE : DRAIN;
                end else begin
                    idx_d       = idx_q + LEN_W'(1);
                    pat_d       = pat_q + DATA_W'(1);
                    ram_en_d    = 1'b1;
                    ram_we_d    = is_fill;
                    ram_addr_d  = ram_addr_q + ADDR_W'(1);
                    ram_wdata_d = is_fill ? pat_q + DATA_W'(1) : '0;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
        // A set wins over a simultaneous clear.
        irq_d = done_d | (irq_q & ~irq_clr);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q          <= IDLE;
            op_q             <= OP_FILL;
            len_q            <= '0;
            idx_q            <= '0;
            pat_q            <= '0;
            ram_en_q         <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_addr_q       <= '0;
            ram_wdata_q      <= '0;
            exp_vld_q        <= 1'b0;
            exp_data_q       <= '0;
            exp_addr_q       <= '0;
            err_cnt_q        <= '0;
            err_seen_q       <= 1'b0;
            first_err_addr_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
            irq_q            <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            len_q            <= len_d;
            idx_q            <= idx_d;
            pat_q            <= pat_d;
            ram_en_q         <= ram_en_d;
            ram_we_q         <= ram_we_d;
            ram_addr_q       <= ram_addr_d;
            ram_wdata_q      <= ram_wdata_d;
            exp_vld_q        <= exp_vld_d;
            exp_data_q       <= exp_data_d;
            exp_addr_q       <= exp_addr_d;
            err_cnt_q        <= err_cnt_d;
            err_seen_q       <= err_seen_d;
            first_err_addr_q <= first_err_addr_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
            irq_q            <= irq_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign err_seen       = err_seen_q;
    assign first_err_addr = first_err_addr_q;
    assign ram_en         = ram_en_q;
    assign ram_we         = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
    assign irq            = irq_q;
`endif

endmodule

// File: tb/tb_pl_ram_cmd_engine.sv
// Self-checking bench for pl_ram_cmd_engine with a pl_ram_sp_bram beside it.
module tb_pl_ram_cmd_engine;
    import pl_ram_ctrl_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 11;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              op;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] seed;
    logic              busy, done, err_seen;
    logic [CNT_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
    logic              irq;
    logic              irq_clr;
`endif

    // Bench-side RAM port, muxed in while the engine is idle.
    logic              tb_sel, tb_en, tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [DATA_W-1:0] tb_wdata;
    logic              m_en, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

    assign m_en    = tb_sel ? tb_en    : ram_en;
    assign m_we    = tb_sel ? tb_we    : ram_we;
    assign m_addr  = tb_sel ? tb_addr  : ram_addr;
    assign m_wdata = tb_sel ? tb_wdata : ram_wdata;

    always #5 clk = ~clk;

    pl_ram_cmd_engine #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .start         (start),
        .op            (op),
        .base_addr     (base_addr),
        .length        (length),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .err_seen      (err_seen),
        .first_err_addr(first_err_addr),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
        ,
        .irq           (irq),
        .irq_clr       (irq_clr)
`endif
    );

    pl_ram_sp_bram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk  (clk),
        .en   (m_en),
        .we   (m_we),
        .addr (m_addr),
        .wdata(m_wdata),
        .rdata(ram_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] model [2**ADDR_W];

    typedef struct {
        logic              op;
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] seed;
        int                lat;
        int                en;
        int                we;
        int                err;
        logic              seen;
        logic [ADDR_W-1:0] first;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ram_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        tb_sel = 1'b1; tb_en = 1'b1; tb_we = 1'b1; tb_addr = a; tb_wdata = d;
        @(negedge clk);
        tb_en = 1'b0; tb_we = 1'b0; tb_sel = 1'b0;
    endtask

    task automatic ram_rd(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        @(negedge clk);
        tb_sel = 1'b1; tb_en = 1'b1; tb_we = 1'b0; tb_addr = a;
        @(negedge clk);
        d = ram_rdata;
        tb_en = 1'b0; tb_sel = 1'b0;
    endtask

    // Issues one command and observes the RAM port until done (bounded).
    // restart_at>0 pulses a conflicting start at that cycle of the pass.
    task automatic run_cmd(input logic op_i, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                           input logic [DATA_W-1:0] s, input int restart_at,
                           output int lat, output int busy_n, output int en_n, output int we_n,
                           output bit seq_ok);
        @(negedge clk);
        start = 1'b1; op = op_i; base_addr = b; length = l; seed = s;
        lat = 0; busy_n = 0; en_n = 0; we_n = 0; seq_ok = 1'b1;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == restart_at) begin
                start = 1'b1; op = ~op_i; base_addr = b + ADDR_W'(5);
                length = LEN_W'(2); seed = s ^ 32'h0000_FFFF;
            end
            if (busy) busy_n++;
            if (ram_en) begin
                if (ram_addr !== b + ADDR_W'(en_n)) seq_ok = 1'b0;
                if (op_i == OP_FILL) begin
                    if (ram_we !== 1'b1 || ram_wdata !== s + DATA_W'(en_n)) seq_ok = 1'b0;
                end else begin
                    if (ram_we !== 1'b0 || ram_wdata !== '0) seq_ok = 1'b0;
                end
                if (ram_we) we_n++;
                en_n++;
            end else if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
                seq_ok = 1'b0;
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_one_cycle_then_idle", {62'd0, done, busy}, 64'd0);
    endtask

    // Reference-model driven command: expectations come from the shadow RAM contents.
    task automatic do_cmd(input logic op_i, input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                          input logic [DATA_W-1:0] s);
        int                exp_cnt;
        bit                seen;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] a;
        int                exp_lat;
        int                lat, bn, en, we;
        bit                ok;
        exp_cnt = 0; seen = 1'b0; exp_first = '0;
        if (op_i == OP_CHECK) begin
            for (int i = 0; i < int'(l); i++) begin
                a = b + ADDR_W'(i);
                if (model[a] !== s + DATA_W'(i)) begin
                    if (!seen) begin
                        seen = 1'b1;
                        exp_first = a;
                    end
                    exp_cnt++;
                end
            end
        end
        if (exp_cnt > 65535) exp_cnt = 65535;
        exp_lat = (l == '0) ? 1 : ((op_i == OP_FILL) ? int'(l) + 1 : int'(l) + 2);
        run_cmd(op_i, b, l, s, 0, lat, bn, en, we, ok);
        check("rnd_latency", 64'(lat), 64'(exp_lat));
        check("rnd_busy_cycles", 64'(bn), 64'(exp_lat));
        check("rnd_en_count", 64'(en), 64'(l));
        check("rnd_we_count", 64'(we), (op_i == OP_FILL) ? 64'(l) : 64'd0);
        check("rnd_ram_sequence", 64'(ok), 64'd1);
        check("rnd_err_cnt", 64'(err_cnt), 64'(exp_cnt));
        check("rnd_err_seen", 64'(err_seen), 64'(seen));
        check("rnd_first_err_addr", 64'(first_err_addr), 64'(exp_first));
        if (op_i == OP_FILL) begin
            for (int i = 0; i < int'(l); i++) model[b + ADDR_W'(i)] = s + DATA_W'(i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                lat, bn, en, we, dcount;
        bit                ok, found;
        logic [DATA_W-1:0] rd;
        logic [ADDR_W-1:0] lb;
        logic [LEN_W-1:0]  ll;
        logic [DATA_W-1:0] ls;

        tbl[0] = '{OP_FILL,  10'h000, 11'd4, 32'h0000_0001, 5, 4, 4, 0, 1'b0, 10'h000};
        tbl[1] = '{OP_CHECK, 10'h000, 11'd4, 32'h0000_0001, 6, 4, 0, 0, 1'b0, 10'h000};
        tbl[2] = '{OP_FILL,  10'h3FE, 11'd4, 32'hFFFF_FFFF, 5, 4, 4, 0, 1'b0, 10'h000};
        tbl[3] = '{OP_FILL,  10'h123, 11'd0, 32'h0000_0007, 1, 0, 0, 0, 1'b0, 10'h000};
        tbl[4] = '{OP_CHECK, 10'h3FE, 11'd4, 32'hFFFF_FFFF, 6, 4, 0, 0, 1'b0, 10'h000};
        tbl[5] = '{OP_CHECK, 10'h010, 11'd0, 32'h0000_0000, 1, 0, 0, 0, 1'b0, 10'h000};

        rst_n = 1'b0; start = 1'b0; op = OP_FILL; base_addr = '0; length = '0; seed = '0;
        tb_sel = 1'b0; tb_en = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        check("reset_err_status", {err_cnt, err_seen, first_err_addr}, 64'd0);
        check("reset_ram_port", {ram_en, ram_we, ram_addr}, 64'd0);
        check("reset_ram_wdata", 64'(ram_wdata), 64'd0);
        rst_n = 1'b1;

        foreach (tbl[v]) begin
            run_cmd(tbl[v].op, tbl[v].base, tbl[v].len, tbl[v].seed, 0, lat, bn, en, we, ok);
            check("tbl_latency", 64'(lat), 64'(tbl[v].lat));
            check("tbl_busy_cycles", 64'(bn), 64'(tbl[v].lat));
            check("tbl_en_count", 64'(en), 64'(tbl[v].en));
            check("tbl_we_count", 64'(we), 64'(tbl[v].we));
            check("tbl_ram_sequence", 64'(ok), 64'd1);
            check("tbl_err_cnt", 64'(err_cnt), 64'(tbl[v].err));
            check("tbl_err_seen", 64'(err_seen), 64'(tbl[v].seen));
            check("tbl_first_err_addr", 64'(first_err_addr), 64'(tbl[v].first));
        end

`ifdef PL_RAM_CMD_ENGINE_IRQ_EN
        check("irq_sticky", 64'(irq), 64'd1);
        @(negedge clk); irq_clr = 1'b1;
        @(negedge clk); irq_clr = 1'b0;
        check("irq_cleared", 64'(irq), 64'd0);
`endif

        // Wrapped fill landed across the top of the RAM.
        ram_rd(10'h3FE, rd); check("wrap_rd_3fe", 64'(rd), 64'hFFFF_FFFF);
        ram_rd(10'h3FF, rd); check("wrap_rd_3ff", 64'(rd), 64'h0);
        ram_rd(10'h000, rd); check("wrap_rd_000", 64'(rd), 64'h1);
        ram_rd(10'h001, rd); check("wrap_rd_001", 64'(rd), 64'h2);
        ram_rd(10'h003, rd); check("fill_rd_003", 64'(rd), 64'h4);

        // Single corrupted word found by a CHECK pass.
        ram_wr(10'h002, 32'h0000_DEAD);
        run_cmd(OP_CHECK, 10'h000, 11'd4, 32'h1, 0, lat, bn, en, we, ok);
        check("corrupt_latency", 64'(lat), 64'd6);
        check("corrupt_err_cnt", 64'(err_cnt), 64'd1);
        check("corrupt_err_seen", 64'(err_seen), 64'd1);
        check("corrupt_first_err_addr", 64'(first_err_addr), 64'h002);
        repeat (5) @(negedge clk);
        check("status_hold", {err_cnt, err_seen, first_err_addr}, {16'd1, 1'b1, 10'h002});

        // Start pulsed mid-pass must be ignored.
        run_cmd(OP_FILL, 10'h200, 11'd8, 32'h0000_1000, 3, lat, bn, en, we, ok);
        check("ign_latency", 64'(lat), 64'd9);
        check("ign_en_count", 64'(en), 64'd8);
        check("ign_we_count", 64'(we), 64'd8);
        check("ign_ram_sequence", 64'(ok), 64'd1);
        ram_rd(10'h207, rd); check("ign_rd_207", 64'(rd), 64'h0000_1007);
        ram_rd(10'h205, rd); check("ign_rd_205", 64'(rd), 64'h0000_1005);

        // Reset asserted at idx=3 of an 8-word fill.
        @(negedge clk);
        start = 1'b1; op = OP_FILL; base_addr = 10'h100; length = 11'd8; seed = 32'h50;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ram_en && ram_addr == 10'h103) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_idx3", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        check("abort_ram_port", {ram_en, ram_we, ram_addr}, 64'd0);
        check("abort_ram_wdata", 64'(ram_wdata), 64'd0);
        check("abort_err_status", {err_cnt, err_seen, first_err_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy || ram_en) dcount++;
        end
        check("abort_quiet_after_release", 64'(dcount), 64'd0);
        run_cmd(OP_FILL, 10'h100, 11'd2, 32'h77, 0, lat, bn, en, we, ok);
        check("post_abort_latency", 64'(lat), 64'd3);
        check("post_abort_we_count", 64'(we), 64'd2);
        ram_rd(10'h101, rd); check("post_abort_rd_101", 64'(rd), 64'h78);

        // Randomised commands against the shadow-RAM model.
        do_cmd(OP_FILL, 10'h000, 11'd1024, 32'hA5A5_0000);
        lb = 10'h000; ll = 11'd1024; ls = 32'hA5A5_0000;
        for (int n = 0; n < 25; n++) begin
            logic              r_op;
            logic [ADDR_W-1:0] r_b;
            logic [LEN_W-1:0]  r_l;
            logic [DATA_W-1:0] r_s;
            r_op = 1'($urandom_range(0, 1));
            r_b  = ADDR_W'($urandom);
            r_l  = LEN_W'($urandom_range(0, 40));
            r_s  = $urandom;
            if (r_op == OP_CHECK && $urandom_range(0, 9) < 7) begin
                r_b = lb; r_l = ll; r_s = ls;
                if (r_l > LEN_W'(40)) r_l = LEN_W'($urandom_range(1, 40));
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    logic [ADDR_W-1:0] ca;
                    logic [DATA_W-1:0] cd;
                    ca = r_b + ADDR_W'($urandom_range(0, 40));
                    cd = $urandom;
                    ram_wr(ca, cd);
                    model[ca] = cd;
                end
            end
            do_cmd(r_op, r_b, r_l, r_s);
            if (r_op == OP_FILL && r_l != '0) begin
                lb = r_b; ll = r_l; ls = r_s;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
